rp_clk_rst_sequencer: RTL and testbench
=======================================

# rp_clk_rst_sequencer

Clock-enable and PERST# sequencer for the root-port simulation model of the CPM QDMA endpoint design. After `start`, it runs the link-up sequence in order: it enables the reference clock, holds PERST# through a warm-up window and a reset-hold window, then releases PERST# and waits for link-up. On link-up timeout or link loss it retries a bounded number of times, then reports an error. It sits between the free-running system clock source and the RP/EP reset pins, and sequences that clock resource for the rest of the testbench.

## Interface
Parameters:
- `WARMUP_CYC`, 100: cycles with `clk_en`=1 and PERST# asserted before the hold window.
- `PERST_CYC`, 1000: cycles PERST# is held low after warm-up and on every retry.
- `LINK_TO_CYC`, 100000: maximum cycles to wait for `link_up` after PERST# release.
- `MAX_RETRY`, 3: retries allowed before entering ERROR.
- `CNT_W`, 20: timer width. It must hold max(WARMUP_CYC, PERST_CYC, LINK_TO_CYC)-1.

Ports:
- `sys_clk` in 1: single clock. One clock; reset is synchronous and active-high.
- `sys_rst` in 1: synchronous, active-high reset.
- `start` in 1: pulse that begins the sequence. Honoured only in IDLE or ERROR.
- `abort` in 1: forces a return to IDLE from any state.
- `link_up` in 1: link-up status, synchronous to `sys_clk`.
- `clk_en` out 1: reference-clock enable to the clock source.
- `perst_n` out 1: PERST#, active-low.
- `busy` out 1: high in WARMUP, HOLD and WAIT_LINK.
- `done` out 1: high only in LINKED.
- `err` out 1: high only in ERROR.
- `retry_cnt` out $clog2(MAX_RETRY+1): retries consumed so far.
- `state` out 3: current state encoding, for debug.

## Operation
States, encodings 0–5:
- **IDLE (0):** `clk_en`=0, `perst_n`=0. `start` → WARMUP, and `retry_cnt` clears.
- **WARMUP (1):** `clk_en`=1, `perst_n`=0. Lasts exactly WARMUP_CYC cycles, then → HOLD.
- **HOLD (2):** `clk_en`=1, `perst_n`=0. Lasts exactly PERST_CYC cycles, then → WAIT_LINK.
- **WAIT_LINK (3):** `clk_en`=1, `perst_n`=1.
  - `link_up`=1 → LINKED.
  - If `link_up` stays 0 for LINK_TO_CYC cycles, a timeout occurs.
- **LINKED (4):** `clk_en`=1, `perst_n`=1, `done`=1. `link_up`=0 is a link-loss event.
- **ERROR (5):** `clk_en`=1, `perst_n`=0, `err`=1. `start` → WARMUP, and `retry_cnt` clears.

Failure handling (timeout or link loss):
- If `retry_cnt` < MAX_RETRY: increment `retry_cnt` and go to HOLD. WARMUP is not repeated.
- Otherwise go to ERROR.

Timer:
- A single timer is reloaded with duration-1 on every state entry.
- It decrements each cycle, and the state exits on the cycle the timer reads 0.

Priority, highest first: `sys_rst` > `abort` > `start` > `link_up` > timer expiry.
- `start` outside IDLE/ERROR is ignored.
- `abort` and `start` in the same cycle: `abort` wins and the block stays in IDLE. A later `start` is needed to begin again.
- `link_up`=1 on the same cycle the WAIT_LINK timer expires: goes to LINKED, not a timeout.
- `abort` mid-sequence: next cycle `clk_en`=0 and `perst_n`=0. `retry_cnt` holds its value until the next `start`.

## Timing
- Reset values: state=IDLE, `clk_en`=0, `perst_n`=0, `busy`=0, `done`=0, `err`=0, `retry_cnt`=0, timer=0.
- All outputs are registered, i.e. decoded from the registered state.
- `start` sampled at edge N: `clk_en` rises at N+1.
- `perst_n` rises at N+1+WARMUP_CYC+PERST_CYC.
- `link_up` sampled high at edge M in WAIT_LINK: `done`=1 from M+1.
- Timeout: with PERST# released at edge R, failure handling takes effect at R+LINK_TO_CYC, and `perst_n`=0 from that edge.
- Link loss sampled at edge L: `done`=0 and `perst_n`=0 from L+1.
- `sys_rst` asserted mid-sequence: outputs reach their reset values on the following edge.

## Structure
- Shared package `rp_seq_pkg`:
  - the state enum and its encodings;
  - state-code constants for debug decode in the bench.
- One sub-module, `rp_seq_timer`: a loadable CNT_W down-counter with ports `load`, `load_val` and `zero`.
- The FSM and retry counter live in the top module.

## Test plan
Bench parameters: WARMUP_CYC=4, PERST_CYC=8, LINK_TO_CYC=16, MAX_RETRY=2.
1. **Nominal:** `start` at edge 10, `link_up`=1 at edge 30 → `clk_en` rises at edge 11, `perst_n` rises at edge 23, `done`=1 from edge 31, `retry_cnt`=0.
2. **Timeout then retry:** `link_up` held 0 → `perst_n` low at edge 39 and high again at edge 47. `link_up`=1 at edge 50 → `done`=1 with `retry_cnt`=1.
3. **Exhaust retries:** `link_up` never asserted → ERROR with `err`=1, `retry_cnt`=2, `perst_n`=0. `start` then restarts the sequence with `retry_cnt`=0.
4. **Link loss in LINKED:** `link_up` drops for 1 cycle → next cycle `done`=0, `perst_n`=0, `retry_cnt`+1, and HOLD lasts 8 cycles.
5. **Collisions:**
   - `link_up` rises on the timer-expiry cycle → LINKED.
   - `abort` together with `start` in IDLE → stays in IDLE.
   - `abort` during HOLD → `clk_en`=0 next cycle.
6. **Synchronous reset mid-WAIT_LINK** → all outputs reach their reset values on the next edge. No reset effect occurs between clock edges.

Source files
------------

// File: rtl/rp_seq_pkg.sv
// Shared types for the root-port clock/PERST# sequencer: state encoding,
// debug state codes and the state-to-output decode.
package rp_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WARMUP    = 3'd1,
        ST_HOLD      = 3'd2,
        ST_WAIT_LINK = 3'd3,
        ST_LINKED    = 3'd4,
        ST_ERROR     = 3'd5
    } rp_state_e;

    localparam logic [2:0] STATE_IDLE      = 3'd0;
    localparam logic [2:0] STATE_WARMUP    = 3'd1;
    localparam logic [2:0] STATE_HOLD      = 3'd2;
    localparam logic [2:0] STATE_WAIT_LINK = 3'd3;
    localparam logic [2:0] STATE_LINKED    = 3'd4;
    localparam logic [2:0] STATE_ERROR     = 3'd5;

    typedef struct packed {
        logic clk_en;
        logic perst_n;
        logic busy;
        logic done;
        logic err;
    } rp_outs_t;

    function automatic rp_outs_t decode_outs(input rp_state_e st);
        rp_outs_t o;
        o = '0;
        case (st)
            ST_WARMUP, ST_HOLD: begin
                o.clk_en = 1'b1;
                o.busy   = 1'b1;
            end
            ST_WAIT_LINK: begin
                o.clk_en  = 1'b1;
                o.perst_n = 1'b1;
                o.busy    = 1'b1;
            end
            ST_LINKED: begin
                o.clk_en  = 1'b1;
                o.perst_n = 1'b1;
                o.done    = 1'b1;
            end
            ST_ERROR: begin
                o.clk_en = 1'b1;
                o.err    = 1'b1;
            end
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/rp_seq_timer.sv
// Loadable down-counter that parks at zero; `zero` flags the final cycle
// of whatever window was loaded.
module rp_seq_timer #(
    parameter int CNT_W = 20
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    // NOTE: sequential state is written with <= so every flop samples the
    // pre-edge values of its inputs regardless of process ordering.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/rp_clk_rst_sequencer.sv
// Reference-clock enable and PERST# sequencer for the root-port model:
// warm-up, PERST# hold, link wait, with bounded retries on failure.
import rp_seq_pkg::*;

module rp_clk_rst_sequencer #(
    parameter int WARMUP_CYC  = 100,
    parameter int PERST_CYC   = 1000,
    parameter int LINK_TO_CYC = 100000,
    parameter int MAX_RETRY   = 3,
    parameter int CNT_W       = 20
) (
    input  logic                               sys_clk,
    input  logic                               sys_rst,
    input  logic                               start,
    input  logic                               abort,
    input  logic                               link_up,
    output logic                               clk_en,
    output logic                               perst_n,
    output logic                               busy,
    output logic                               done,
    output logic                               err,
    output logic [$clog2(MAX_RETRY+1)-1:0]     retry_cnt,
    output logic [2:0]                         state
);

    localparam int RW = $clog2(MAX_RETRY + 1);

    localparam logic [CNT_W-1:0] WARMUP_LOAD = CNT_W'(WARMUP_CYC - 1);
    localparam logic [CNT_W-1:0] PERST_LOAD  = CNT_W'(PERST_CYC - 1);
    localparam logic [CNT_W-1:0] LINK_LOAD   = CNT_W'(LINK_TO_CYC - 1);

    rp_state_e        state_q;
    rp_state_e        state_d;
    logic             fail;
    logic             restart;
    logic             timer_load;
    logic [CNT_W-1:0] timer_val;
    logic             timer_zero;
    rp_outs_t         outs;

    rp_seq_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .load     (timer_load),
        .load_val (timer_val),
        .zero     (timer_zero)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        fail    = 1'b0;
        restart = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_ERROR: begin
                    if (start) begin
                        state_d = ST_WARMUP;
                        restart = 1'b1;
                    end
                end
                ST_WARMUP:    if (timer_zero) state_d = ST_HOLD;
                ST_HOLD:      if (timer_zero) state_d = ST_WAIT_LINK;
                ST_WAIT_LINK: begin
                    if (link_up)         state_d = ST_LINKED;
                    else if (timer_zero) fail    = 1'b1;
                end
                ST_LINKED:    if (!link_up) fail = 1'b1;
                default:      state_d = ST_IDLE;
            endcase
            // Both timeout and link loss go back to HOLD; WARMUP is not rerun.
            if (fail) begin
                state_d = (retry_cnt < RW'(MAX_RETRY)) ? ST_HOLD : ST_ERROR;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            retry_cnt <= '0;
        end else if (restart) begin
            retry_cnt <= '0;
        end else if (fail && (retry_cnt < RW'(MAX_RETRY))) begin
            retry_cnt <= retry_cnt + RW'(1);
        end
    end

    // Timer reloads on any state change with the new state's window minus one.
    always_comb begin
        timer_load = (state_d != state_q);
        case (state_d)
            ST_WARMUP:    timer_val = WARMUP_LOAD;
            ST_HOLD:      timer_val = PERST_LOAD;
            ST_WAIT_LINK: timer_val = LINK_LOAD;
            default:      timer_val = '0;
        endcase
    end

    always_comb begin
        outs = decode_outs(state_q);
    end

    assign clk_en  = outs.clk_en;
    assign perst_n = outs.perst_n;
    assign busy    = outs.busy;
    assign done    = outs.done;
    assign err     = outs.err;
    assign state   = state_q;

endmodule

// File: tb/tb_rp_clk_rst_sequencer.sv
// Bench for rp_clk_rst_sequencer: cycle-count reference model compared every
// cycle, directed timing scenarios with literal edge expectations, random tail.
module tb_rp_clk_rst_sequencer;
    import rp_seq_pkg::*;

    localparam int WARMUP_CYC  = 4;
    localparam int PERST_CYC   = 8;
    localparam int LINK_TO_CYC = 16;
    localparam int MAX_RETRY   = 2;
    localparam int CNT_W       = 20;

    localparam int P_IDLE   = int'(STATE_IDLE);
    localparam int P_WARMUP = int'(STATE_WARMUP);
    localparam int P_HOLD   = int'(STATE_HOLD);
    localparam int P_WAIT   = int'(STATE_WAIT_LINK);
    localparam int P_LINKED = int'(STATE_LINKED);
    localparam int P_ERROR  = int'(STATE_ERROR);

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       start   = 1'b0;
    logic       abort   = 1'b0;
    logic       link_up = 1'b0;
    logic       clk_en, perst_n, busy, done, err;
    logic [1:0] retry_cnt;
    logic [2:0] state;

    int total = 0;
    int bad   = 0;
    int edge_n = 0;
    int base   = 0;
    bit cmp_on = 1'b0;

    // Model: phase, cycles spent in current timed phase, retries used.
    int m_ph = P_IDLE;
    int m_el = 0;
    int m_rc = 0;

    rp_clk_rst_sequencer #(
        .WARMUP_CYC  (WARMUP_CYC),
        .PERST_CYC   (PERST_CYC),
        .LINK_TO_CYC (LINK_TO_CYC),
        .MAX_RETRY   (MAX_RETRY),
        .CNT_W       (CNT_W)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .start     (start),
        .abort     (abort),
        .link_up   (link_up),
        .clk_en    (clk_en),
        .perst_n   (perst_n),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .retry_cnt (retry_cnt),
        .state     (state)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_n - base, act, exp);
        end
    endtask

    always @(posedge sys_clk) begin : model
        int ph, el, rc;
        bit fail;
        ph = m_ph; el = m_el; rc = m_rc; fail = 1'b0;
        if (sys_rst) begin
            ph = P_IDLE; el = 0; rc = 0;
        end else if (abort) begin
            ph = P_IDLE; el = 0;
        end else begin
            case (ph)
                P_IDLE, P_ERROR: if (start) begin ph = P_WARMUP; el = 0; rc = 0; end
                P_WARMUP: begin el++; if (el == WARMUP_CYC) begin ph = P_HOLD; el = 0; end end
                P_HOLD:   begin el++; if (el == PERST_CYC)  begin ph = P_WAIT; el = 0; end end
                P_WAIT: begin
                    if (link_up) begin ph = P_LINKED; el = 0; end
                    else begin el++; if (el == LINK_TO_CYC) fail = 1'b1; end
                end
                P_LINKED: if (!link_up) fail = 1'b1;
                default: ;
            endcase
            if (fail) begin
                el = 0;
                if (rc < MAX_RETRY) begin rc++; ph = P_HOLD; end
                else ph = P_ERROR;
            end
        end
        m_ph <= ph;
        m_el <= el;
        m_rc <= rc;
    end

    // Per-cycle comparison on the falling edge, away from the sampling edge.
    always @(negedge sys_clk) begin
        if (cmp_on) begin
            check("state",     32'(state),     32'(m_ph));
            check("clk_en",    32'(clk_en),    32'(m_ph != P_IDLE));
            check("perst_n",   32'(perst_n),   32'(m_ph == P_WAIT || m_ph == P_LINKED));
            check("busy",      32'(busy),      32'(m_ph == P_WARMUP || m_ph == P_HOLD || m_ph == P_WAIT));
            check("done",      32'(done),      32'(m_ph == P_LINKED));
            check("err",       32'(err),       32'(m_ph == P_ERROR));
            check("retry_cnt", 32'(retry_cnt), 32'(m_rc));
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        edge_n++;
        #1;
    endtask

    task automatic tick_to(input int n);
        while (edge_n - base < n) tick();
    endtask

    task automatic restart();
        sys_rst = 1'b1; abort = 1'b0; start = 1'b0; link_up = 1'b0;
        tick();
        sys_rst = 1'b0;
        base = edge_n;
    endtask

    // Start is raised right after edge 10, so it is sampled at edge 11.
    task automatic kick_at_10();
        tick_to(10);
        start = 1'b1;
        tick_to(11);
        start = 1'b0;
    endtask

    initial begin
        tick();
        cmp_on = 1'b1;
        tick();
        check("reset state",   32'(state),     32'(STATE_IDLE));
        check("reset perst_n", 32'(perst_n),   32'd0);
        check("reset clk_en",  32'(clk_en),    32'd0);
        check("reset retry",   32'(retry_cnt), 32'd0);

        // Nominal bring-up.
        restart();
        tick_to(10);
        check("s1 clk_en@10", 32'(clk_en), 32'd0);
        kick_at_10();
        check("s1 clk_en@11",   32'(clk_en), 32'd1);
        check("s1 model ph@11", 32'(m_ph),   32'(P_WARMUP));
        tick_to(22);
        check("s1 perst_n@22", 32'(perst_n), 32'd0);
        tick_to(23);
        check("s1 perst_n@23",  32'(perst_n), 32'd1);
        check("s1 model ph@23", 32'(m_ph),    32'(P_WAIT));
        tick_to(30);
        check("s1 done@30", 32'(done), 32'd0);
        link_up = 1'b1;
        tick_to(31);
        check("s1 done@31",  32'(done),      32'd1);
        check("s1 retry@31", 32'(retry_cnt), 32'd0);

        // Timeout, retry from HOLD, then link.
        restart();
        kick_at_10();
        tick_to(38);
        check("s2 perst_n@38", 32'(perst_n), 32'd1);
        tick_to(39);
        check("s2 perst_n@39",  32'(perst_n),   32'd0);
        check("s2 retry@39",    32'(retry_cnt), 32'd1);
        check("s2 model rc@39", 32'(m_rc),      32'd1);
        tick_to(46);
        check("s2 perst_n@46", 32'(perst_n), 32'd0);
        tick_to(47);
        check("s2 perst_n@47", 32'(perst_n), 32'd1);
        tick_to(50);
        link_up = 1'b1;
        tick_to(51);
        check("s2 done@51",  32'(done),      32'd1);
        check("s2 retry@51", 32'(retry_cnt), 32'd1);

        // Retries exhausted, then restart from ERROR.
        restart();
        kick_at_10();
        tick_to(86);
        check("s3 err@86", 32'(err), 32'd0);
        tick_to(87);
        check("s3 err@87",      32'(err),       32'd1);
        check("s3 state@87",    32'(state),     32'(STATE_ERROR));
        check("s3 retry@87",    32'(retry_cnt), 32'd2);
        check("s3 perst_n@87",  32'(perst_n),   32'd0);
        check("s3 model ph@87", 32'(m_ph),      32'(P_ERROR));
        tick_to(90);
        start = 1'b1;
        tick_to(91);
        start = 1'b0;
        check("s3 state@91", 32'(state),     32'(STATE_WARMUP));
        check("s3 retry@91", 32'(retry_cnt), 32'd0);

        // One-cycle link loss while LINKED.
        restart();
        kick_at_10();
        tick_to(30);
        link_up = 1'b1;
        tick_to(40);
        check("s4 done@40", 32'(done), 32'd1);
        link_up = 1'b0;
        tick_to(41);
        link_up = 1'b1;
        check("s4 done@41",    32'(done),      32'd0);
        check("s4 perst_n@41", 32'(perst_n),   32'd0);
        check("s4 retry@41",   32'(retry_cnt), 32'd1);
        tick_to(48);
        check("s4 perst_n@48", 32'(perst_n), 32'd0);
        tick_to(49);
        check("s4 perst_n@49", 32'(perst_n), 32'd1);
        tick_to(50);
        check("s4 done@50", 32'(done), 32'd1);

        // link_up on the timer-expiry cycle wins over the timeout.
        restart();
        kick_at_10();
        tick_to(38);
        link_up = 1'b1;
        tick_to(39);
        check("s5a state@39", 32'(state),     32'(STATE_LINKED));
        check("s5a retry@39", 32'(retry_cnt), 32'd0);

        // abort with start in IDLE stays in IDLE.
        restart();
        tick_to(10);
        start = 1'b1; abort = 1'b1;
        tick_to(11);
        start = 1'b0; abort = 1'b0;
        check("s5b state@11",  32'(state),  32'(STATE_IDLE));
        check("s5b clk_en@11", 32'(clk_en), 32'd0);

        // abort during HOLD drops the clock next cycle.
        restart();
        kick_at_10();
        tick_to(17);
        check("s5c state@17", 32'(state), 32'(STATE_HOLD));
        abort = 1'b1;
        tick_to(18);
        abort = 1'b0;
        check("s5c clk_en@18", 32'(clk_en), 32'd0);
        check("s5c state@18",  32'(state),  32'(STATE_IDLE));

        // Synchronous reset during WAIT_LINK.
        restart();
        kick_at_10();
        tick_to(26);
        sys_rst = 1'b1;
        #2;
        check("s6 perst_n before edge", 32'(perst_n), 32'd1);
        check("s6 state before edge",   32'(state),   32'(STATE_WAIT_LINK));
        tick_to(27);
        sys_rst = 1'b0;
        check("s6 state@27",   32'(state),   32'(STATE_IDLE));
        check("s6 clk_en@27",  32'(clk_en),  32'd0);
        check("s6 perst_n@27", 32'(perst_n), 32'd0);
        check("s6 busy@27",    32'(busy),    32'd0);

        // Random tail against the per-cycle model.
        restart();
        for (int i = 0; i < 4000; i++) begin
            sys_rst = ($urandom_range(0, 299) == 0);
            abort   = ($urandom_range(0, 149) == 0);
            start   = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 19) == 0) link_up = ~link_up;
            tick();
        end
        sys_rst = 1'b0; abort = 1'b0; start = 1'b0;
        tick();
        cmp_on = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
